// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache facing the core's MEM/WB port.
// Hits return one cycle after acceptance; misses and writes go to a word-wide memory handshake.
module dcache_responder #(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] dcache_addr,
  input  logic [3:0]  dcache_we,
  input  logic        dcache_re,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [29:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_FILL_REQ,
    S_FILL_WAIT
  } state_t;

  state_t            state;
  logic              req_pending;
  logic              fill_done;
  logic [29:0]       req_addr;
  logic [3:0]        req_we;
  logic [31:0]       req_din;
  logic [OFF_W-1:0]  cnt;
  logic [LINES-1:0]  valid;
  logic [31:0]       dout_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES*WORDS_PER_LINE];

  logic [OFF_W-1:0]  req_word;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              req_is_wr;
  logic              hit;
  logic [31:0]       hit_word;
  logic              lookup;
  logic              rd_hit;
  logic              accept;
  logic              unused_byte_off;

  assign unused_byte_off = ^dcache_addr[1:0];

  assign req_word  = req_addr[OFF_W-1:0];
  assign req_idx   = req_addr[OFF_W +: IDX_W];
  assign req_tag   = req_addr[29 -: TAG_W];
  assign req_is_wr = |req_we;
  assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign hit_word  = data_mem[{req_idx, req_word}];
  assign lookup    = (state == S_IDLE) && req_pending;
  assign rd_hit    = lookup && !req_is_wr && hit;

  assign stall       = (state != S_IDLE) || (lookup && !rd_hit);
  // The cycle right after a fill replays the held read as a hit; the core is
  // still presenting that same request, so acceptance is suppressed there.
  assign accept      = !stall && !fill_done && (dcache_re || (|dcache_we));
  assign dcache_dout = rd_hit ? hit_word : dout_q;

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;
    case (state)
      S_WR: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = req_addr;
        mem_req_wdata = req_din;
        mem_req_wmask = req_we;
      end
      S_FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_idx, cnt};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      req_pending <= 1'b0;
      fill_done   <= 1'b0;
      req_addr    <= '0;
      req_we      <= '0;
      req_din     <= '0;
      cnt         <= '0;
      valid       <= '0;
      dout_q      <= '0;
    end else begin
      fill_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_pending) begin
            if (req_is_wr) begin
              state <= S_WR;
            end else if (hit) begin
              dout_q      <= hit_word;
              req_pending <= 1'b0;
            end else begin
              state <= S_FILL_REQ;
              cnt   <= '0;
            end
          end
        end
        S_WR: begin
          if (mem_req_ready) begin
            state       <= S_IDLE;
            req_pending <= 1'b0;
          end
        end
        S_FILL_REQ: begin
          if (mem_req_ready) state <= S_FILL_WAIT;
        end
        S_FILL_WAIT: begin
          if (mem_resp_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_WORD) begin
              valid[req_idx] <= 1'b1;
              state          <= S_IDLE;
              fill_done      <= 1'b1;
            end else begin
              state <= S_FILL_REQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      if (accept) begin
        req_pending <= 1'b1;
        req_addr    <= dcache_addr[31:2];
        req_we      <= dcache_we;
        req_din     <= dcache_din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_FILL_WAIT && mem_resp_valid) begin
      data_mem[{req_idx, cnt}] <= mem_resp_data;
      if (cnt == LAST_WORD) tag_mem[req_idx] <= req_tag;
    end else if (lookup && req_is_wr && hit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (req_we[b]) data_mem[{req_idx, req_word}][8*b +: 8] <= req_din[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a behavioural word-wide backing memory.
// Expected data comes from the memory model's fixed contents plus the writes it has seen.
module tb_dcache_responder;

  logic        clk;
  logic        reset_n;
  logic [31:0] dcache_addr;
  logic [3:0]  dcache_we;
  logic        dcache_re;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  dcache_responder #(.LINES(16), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .dcache_addr(dcache_addr), .dcache_we(dcache_we), .dcache_re(dcache_re),
    .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Backing memory: line 0x40 holds 0xA0+n, every other word holds its own word address.
  logic [31:0] wmem [logic [29:0]];
  logic [29:0] rd_log [$];
  int unsigned wr_count = 0;
  logic [29:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  int unsigned idle_viol = 0;
  int unsigned resp_lat  = 1;
  int unsigned resp_cnt  = 0;
  logic        resp_pend = 1'b0;
  logic [29:0] resp_addr;
  logic [31:0] wv;

  function automatic logic [31:0] mem_val(input logic [29:0] a);
    if (wmem.exists(a)) return wmem[a];
    if (a[29:2] == 28'h10) return 32'hA0 + {30'b0, a[1:0]};
    return {2'b0, a};
  endfunction

  always @(negedge clk) begin
    mem_resp_valid = 1'b0;
    if (!reset_n) begin
      resp_pend = 1'b0;
    end else begin
      if (resp_pend) begin
        if (resp_cnt <= 1) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_val(resp_addr);
          resp_pend      = 1'b0;
        end else begin
          resp_cnt--;
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        if (mem_req_we) begin
          wr_count++;
          wr_addr = mem_req_addr;
          wr_data = mem_req_wdata;
          wr_mask = mem_req_wmask;
          wv = mem_val(mem_req_addr);
          for (int b = 0; b < 4; b++)
            if (mem_req_wmask[b]) wv[8*b +: 8] = mem_req_wdata[8*b +: 8];
          wmem[mem_req_addr] = wv;
        end else begin
          rd_log.push_back(mem_req_addr);
          resp_pend = 1'b1;
          resp_cnt  = resp_lat;
          resp_addr = mem_req_addr;
        end
      end
      if (!mem_req_valid && (mem_req_we || (|mem_req_addr) || (|mem_req_wdata) || (|mem_req_wmask)))
        idle_viol++;
    end
  end

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int unsigned cyc);
    @(negedge clk);
    dcache_addr = a;
    dcache_we   = 4'b0000;
    dcache_re   = 1'b1;
    @(posedge clk);
    #1 dcache_re = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (stall && cyc < 200);
    check("rd_done", 32'(stall), 32'd0);
    d = dcache_dout;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] din);
    int unsigned cyc;
    @(negedge clk);
    dcache_addr = a;
    dcache_we   = we;
    dcache_din  = din;
    @(posedge clk);
    #1 dcache_we = 4'b0000;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (stall && cyc < 200);
    check("wr_done", 32'(stall), 32'd0);
  endtask

  task automatic check_fill(input string tag, input int unsigned start, input logic [29:0] base);
    check({tag, "_nreq"}, 32'(rd_log.size()) - 32'(start), 32'd4);
    for (int unsigned i = 0; i < 4; i++)
      if (start + i < rd_log.size())
        check({tag, "_addr"}, {2'b0, rd_log[start+i]}, {2'b0, base + 30'(i)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int unsigned cyc;
    int unsigned n0;
    int unsigned w0;
    int unsigned bp_bad;

    reset_n       = 1'b0;
    dcache_addr   = '0;
    dcache_we     = '0;
    dcache_re     = 1'b0;
    dcache_din    = '0;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_dout", dcache_dout, 32'd0);
    check("rst_mvalid", 32'(mem_req_valid), 32'd0);
    reset_n = 1'b1;

    // Cold read miss
    n0 = rd_log.size();
    do_read(32'h0000_0104, d, cyc);
    check_fill("cold", n0, 30'h40);
    check("cold_dout", d, 32'h0000_00A1);
    check("cold_stalled", 32'(cyc > 1), 32'd1);

    // Same-line hit
    n0 = rd_log.size();
    do_read(32'h0000_010C, d, cyc);
    check("hit_nreq", 32'(rd_log.size()) - 32'(n0), 32'd0);
    check("hit_lat", 32'(cyc), 32'd1);
    check("hit_dout", d, 32'h0000_00A3);

    // Write hit with partial mask, then read back
    w0 = wr_count;
    do_write(32'h0000_0104, 4'b0011, 32'hDEAD_BEEF);
    check("wh_nwr", 32'(wr_count - w0), 32'd1);
    check("wh_addr", {2'b0, wr_addr}, 32'h41);
    check("wh_data", wr_data, 32'hDEAD_BEEF);
    check("wh_mask", {28'b0, wr_mask}, 32'h3);
    n0 = rd_log.size();
    do_read(32'h0000_0104, d, cyc);
    check("wh_rd_nreq", 32'(rd_log.size()) - 32'(n0), 32'd0);
    check("wh_rd_lat", 32'(cyc), 32'd1);
    check("wh_rd_dout", d, 32'h0000_BEEF);

    // Write miss: no allocation, the read that follows must fill
    w0 = wr_count;
    do_write(32'h0000_2000, 4'b1111, 32'h1234_5678);
    check("wm_nwr", 32'(wr_count - w0), 32'd1);
    check("wm_addr", {2'b0, wr_addr}, 32'h800);
    check("wm_mask", {28'b0, wr_mask}, 32'hF);
    n0 = rd_log.size();
    do_read(32'h0000_2000, d, cyc);
    check_fill("wm_rd", n0, 30'h800);
    check("wm_rd_dout", d, 32'h1234_5678);

    // Conflicts on index 0
    n0 = rd_log.size();
    do_read(32'h0000_0104, d, cyc);
    check_fill("cf1", n0, 30'h40);
    check("cf1_dout", d, 32'h0000_BEEF);
    n0 = rd_log.size();
    do_read(32'h0001_0104, d, cyc);
    check_fill("cf2", n0, 30'h4040);
    check("cf2_dout", d, 32'h0000_4041);
    n0 = rd_log.size();
    do_read(32'h0000_0104, d, cyc);
    check_fill("cf3", n0, 30'h40);
    check("cf3_dout", d, 32'h0000_BEEF);

    // Backpressure in FILL_REQ, then reset during FILL_WAIT
    @(posedge clk);
    #1 mem_req_ready = 1'b0;
    resp_lat = 4;
    n0 = rd_log.size();
    @(negedge clk);
    dcache_addr = 32'h0000_0550;
    dcache_re   = 1'b1;
    @(posedge clk);
    #1 dcache_re = 1'b0;
    @(negedge clk);
    check("bp_lookup_stall", 32'(stall), 32'd1);
    bp_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!mem_req_valid || mem_req_we || mem_req_addr != 30'h154 || !stall) bp_bad++;
    end
    check("bp_hold", 32'(bp_bad), 32'd0);
    @(posedge clk);
    #1 mem_req_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2;
    check("bp_wait_mvalid", 32'(mem_req_valid), 32'd0);
    check("bp_wait_stall", 32'(stall), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_fill_stall", 32'(stall), 32'd0);
    check("rst_fill_mvalid", 32'(mem_req_valid), 32'd0);
    check("rst_fill_nreq", 32'(rd_log.size()) - 32'(n0), 32'd1);
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    resp_lat = 1;
    n0 = rd_log.size();
    do_read(32'h0000_0550, d, cyc);
    check_fill("rst_reread", n0, 30'h154);
    check("rst_reread_dout", d, 32'h0000_0154);

    check("idle_zero", 32'(idle_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
